// File: rtl/mem_axi_arbiter_pkg.sv
// Shared types for the memory/fetch AXI4-lite arbiter: FSM encoding, source ids
// and AXI response constants.
package mem_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } arb_state_e;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } arb_src_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Pick the 32-bit instruction word out of a 64-bit beat by address bit 2.
    function automatic logic [31:0] fetch_lane(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_axi_arbiter.sv
// Arbitrates instruction fetch and MEM-stage data accesses onto a single
// AXI4-lite master port, one transaction at a time. Requires DATA_W >= 64.
module mem_axi_arbiter
    import mem_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch port
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [31:0]           if_rdata_o,
    output logic                  if_ready_o,
    // data port
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic [DATA_W/8-1:0]   mem_wstrb_i,
    output logic [DATA_W-1:0]     mem_rdata_o,
    output logic                  mem_ready_o,
    output logic                  mem_err_o,
    output logic                  stall_o,
    // AXI4-lite master
    output logic [ADDR_W-1:0]     araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q;
    arb_src_e            src_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                aw_done_q, w_done_q;
    logic                aw_done_d, w_done_d;
    logic                if_ready_q, mem_ready_q, mem_err_q;
    logic [31:0]         if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;
    logic                pulse_busy;

    assign aw_done_d  = aw_done_q | (awvalid_q & awready_i);
    assign w_done_d   = w_done_q  | (wvalid_q  & wready_i);
    // A requester still holds its level in the cycle its ready pulse is out.
    assign pulse_busy = if_ready_q | mem_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!pulse_busy && (mem_write_i || mem_read_i || if_req_i)) begin
                        wdata_q <= mem_wdata_i;
                        wstrb_q <= mem_wstrb_i;
                        if (mem_write_i) begin
                            addr_q    <= mem_addr_i;
                            src_q     <= SRC_MEM;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR_REQ;
                        end else if (mem_read_i) begin
                            addr_q    <= mem_addr_i;
                            src_q     <= SRC_MEM;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end else begin
                            addr_q    <= if_addr_i;
                            src_q     <= SRC_IF;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid_i) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                        // Fetch errors are swallowed; the core sees a normal completion.
                        if (src_q == SRC_IF) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= fetch_lane(rdata_i[63:0], addr_q[2]);
                        end else begin
                            mem_ready_q <= 1'b1;
                            mem_rdata_q <= rdata_i;
                            mem_err_q   <= (rresp_i != RESP_OKAY);
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && awready_i) awvalid_q <= 1'b0;
                    if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid_i) begin
                        bready_q    <= 1'b0;
                        mem_ready_q <= 1'b1;
                        mem_err_q   <= (bresp_i != RESP_OKAY);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_o    = (mem_read_i | mem_write_i) & ~mem_ready_q;

    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ready_o = mem_ready_q;
    assign mem_err_o   = mem_err_q;

    assign araddr_o  = addr_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign awaddr_o  = addr_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Scoreboard bench for mem_axi_arbiter: directed fetch/read/write scenarios
// against a small AXI4-lite slave model with per-test channel latencies.
module tb_mem_axi_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                if_req_i = 1'b0;
    logic [ADDR_W-1:0]   if_addr_i = '0;
    logic [31:0]         if_rdata_o;
    logic                if_ready_o;
    logic                mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [ADDR_W-1:0]   mem_addr_i = '0;
    logic [DATA_W-1:0]   mem_wdata_i = '0;
    logic [STRB_W-1:0]   mem_wstrb_i = '0;
    logic [DATA_W-1:0]   mem_rdata_o;
    logic                mem_ready_o, mem_err_o, stall_o;
    logic [ADDR_W-1:0]   araddr_o, awaddr_o;
    logic                arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o;
    logic                arready_i = 1'b0, rvalid_i = 1'b0, awready_i = 1'b0;
    logic                wready_i = 1'b0, bvalid_i = 1'b0;
    logic [DATA_W-1:0]   rdata_i = '0;
    logic [1:0]          rresp_i = '0, bresp_i = '0;
    logic [DATA_W-1:0]   wdata_o;
    logic [STRB_W-1:0]   wstrb_o;

    mem_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i), .mem_rdata_o(mem_rdata_o),
        .mem_ready_o(mem_ready_o), .mem_err_o(mem_err_o), .stall_o(stall_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    typedef struct {
        bit          is_if;
        logic [63:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (if_ready_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected_if: got if_ready_o=1 expected no completion");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_src_is_if", 64'(e.is_if), 64'd1);
                    chk("sb_if_rdata", 64'(if_rdata_o), e.data);
                end
            end
            if (mem_ready_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected_mem: got mem_ready_o=1 expected no completion");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_src_is_mem", 64'(e.is_if), 64'd0);
                    chk("sb_mem_rdata", mem_rdata_o, e.data);
                    chk("sb_mem_err", 64'(mem_err_o), 64'(e.err));
                end
            end
            if (mem_err_o && !mem_ready_o) begin
                checks++; errors++;
                $display("FAIL err_without_ready: got mem_err_o=1 expected 0 outside a completion");
            end
        end
    end

    // ---------------- AXI4-lite slave model ----------------
    int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0;
    logic [63:0] rd_data_v = '0;
    logic [1:0]  rresp_v = '0, bresp_v = '0;
    int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, prot_errs = 0;
    logic [31:0] last_awaddr = '0;
    logic [63:0] last_wdata = '0;
    logic [7:0]  last_wstrb = '0;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_active, aw_seen, w_seen;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt;

    // Handshakes are predicted at the negedge and consumed one cycle later,
    // since everything the next posedge samples is stable from here on.
    always @(negedge clk) begin
        if (rst) begin
            arready_i = 0; rvalid_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            rd_active = 0; aw_seen = 0; w_seen = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            if (ar_hs) begin n_ar++; rd_active = 1; r_cnt = 0; ar_cnt = 0; end
            if (r_hs)  begin n_r++; rd_active = 0; end
            if (aw_hs) begin n_aw++; aw_seen = 1; aw_cnt = 0; last_awaddr = awaddr_o; end
            if (w_hs)  begin n_w++; w_seen = 1; w_cnt = 0; last_wdata = wdata_o; last_wstrb = wstrb_o; end
            if (b_hs)  begin n_b++; aw_seen = 0; w_seen = 0; end

            if (arvalid_o && (rd_active || aw_seen || w_seen || awvalid_o || wvalid_o)) prot_errs++;
            if ((awvalid_o || wvalid_o) && rd_active) prot_errs++;
            if ((awvalid_o && aw_seen) || (wvalid_o && w_seen)) prot_errs++;
            if (bready_o && (awvalid_o || wvalid_o)) prot_errs++;

            if (arvalid_o) begin arready_i = (ar_cnt >= ar_lat); ar_cnt++; end
            else begin arready_i = 0; ar_cnt = 0; end
            if (rd_active) begin
                rvalid_i = (r_cnt >= r_lat); r_cnt++;
                rdata_i = rd_data_v; rresp_i = rresp_v;
            end else rvalid_i = 0;
            if (awvalid_o) begin awready_i = (aw_cnt >= aw_lat); aw_cnt++; end
            else begin awready_i = 0; aw_cnt = 0; end
            if (wvalid_o) begin wready_i = (w_cnt >= w_lat); w_cnt++; end
            else begin wready_i = 0; w_cnt = 0; end
            bvalid_i = aw_seen && w_seen;
            bresp_i  = bresp_v;

            ar_hs = arvalid_o && arready_i;
            r_hs  = rvalid_i && rready_o;
            aw_hs = awvalid_o && awready_i;
            w_hs  = wvalid_o && wready_i;
            b_hs  = bvalid_i && bready_o;
        end
    end

    // ---------------- driver helpers ----------------
    logic [63:0] last_mem_rd = '0;

    task automatic wait_mem(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!mem_ready_o && n < 200);
        if (!mem_ready_o) begin
            checks++; errors++;
            $display("FAIL %s: got no mem_ready_o expected completion within 200 cycles", name);
        end
    endtask

    task automatic wait_if(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!if_ready_o && n < 400);
        if (!if_ready_o) begin
            checks++; errors++;
            $display("FAIL %s: got no if_ready_o expected completion within 400 cycles", name);
        end
    endtask

    task automatic mem_txn(input bit wr, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws);
        mem_addr_i = addr; mem_wdata_i = wd; mem_wstrb_i = ws;
        if (wr) mem_write_i = 1'b1; else mem_read_i = 1'b1;
        wait_mem(wr ? "mem_write_done" : "mem_read_done");
        mem_write_i = 1'b0; mem_read_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, w0, b0;
        logic [1:0] lat_tab [3][2];
        lat_tab = '{'{0, 1}, '{1, 0}, '{0, 0}};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl_outs", 64'({arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o,
                                  if_ready_o, mem_ready_o, mem_err_o, stall_o}), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata_o), 64'd0);
        chk("rst_mem_rdata", mem_rdata_o, 64'd0);
        chk("rst_araddr", 64'(araddr_o), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // fetch @0x8000_0004, arready after 2 cycles, upper word returned
        ar_lat = 2; rd_data_v = 64'h1111_2222_3333_4444;
        sb.push_back('{1, 64'h1111_2222, 0});
        a0 = n_ar;
        if_addr_i = 32'h8000_0004; if_req_i = 1'b1;
        @(negedge clk);
        chk("fetch_arvalid_n1", 64'(arvalid_o), 64'd1);
        chk("fetch_araddr", 64'(araddr_o), 64'h8000_0004);
        @(negedge clk);
        chk("fetch_araddr_held", 64'({arvalid_o, araddr_o}), {31'd0, 1'b1, 32'h8000_0004});
        wait_if("fetch_done");
        if_req_i = 1'b0;
        @(negedge clk);
        chk("fetch_single_pulse", 64'(if_ready_o), 64'd0);
        chk("fetch_ar_count", 64'(n_ar - a0), 64'd1);
        ar_lat = 0;

        // write and fetch raised together: write first, fetch waits
        rd_data_v = 64'hAAAA_BBBB_CCCC_DDDD;
        sb.push_back('{0, last_mem_rd, 0});
        sb.push_back('{1, 64'hCCCC_DDDD, 0});
        a0 = n_ar;
        mem_addr_i = 32'h100; mem_wdata_i = 64'hDEAD_BEEF; mem_wstrb_i = 8'h0F; mem_write_i = 1'b1;
        if_addr_i = 32'h200; if_req_i = 1'b1;
        #1 chk("wf_stall_initial", 64'(stall_o), 64'd1);
        fork
            begin
                int n = 0;
                do begin
                    @(negedge clk); n++;
                    if (!mem_ready_o) chk("wf_stall_held", 64'(stall_o), 64'd1);
                end while (!mem_ready_o && n < 200);
                chk("wf_write_ready", 64'(mem_ready_o), 64'd1);
                chk("wf_stall_released", 64'(stall_o), 64'd0);
                chk("wf_fetch_not_issued", 64'(n_ar - a0), 64'd0);
                mem_write_i = 1'b0;
            end
            begin
                wait_if("wf_fetch_done");
                if_req_i = 1'b0;
            end
        join
        chk("wf_awaddr", 64'(last_awaddr), 64'h100);
        chk("wf_wdata", last_wdata, 64'hDEAD_BEEF);
        chk("wf_wstrb", 64'(last_wstrb), 64'h0F);
        @(negedge clk);

        // aw/w handshakes in either order or together
        for (int k = 0; k < 3; k++) begin
            aw_lat = lat_tab[k][0]; w_lat = lat_tab[k][1];
            a0 = n_aw; w0 = n_w; b0 = n_b;
            sb.push_back('{0, last_mem_rd, 0});
            mem_txn(1, 32'h40 + 32'(k * 8), 64'h1000 + 64'(k), 8'hFF);
            @(negedge clk);
            chk("wr_aw_once", 64'(n_aw - a0), 64'd1);
            chk("wr_w_once", 64'(n_w - w0), 64'd1);
            chk("wr_b_once", 64'(n_b - b0), 64'd1);
            chk("wr_wdata", last_wdata, 64'h1000 + 64'(k));
        end
        aw_lat = 0; w_lat = 0;

        // read with SLVERR response
        rd_data_v = 64'h0123_4567_89AB_CDEF; rresp_v = 2'b10;
        sb.push_back('{0, 64'h0123_4567_89AB_CDEF, 1});
        mem_txn(0, 32'h300, '0, '0);
        last_mem_rd = 64'h0123_4567_89AB_CDEF;
        rresp_v = 2'b00;
        @(negedge clk);

        // reset while waiting in RD_DATA
        r_lat = 6;
        mem_addr_i = 32'h400; mem_read_i = 1'b1;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!rready_o && n < 50);
            chk("rstmid_reached_rd_data", 64'(rready_o), 64'd1);
        end
        #2 rst = 1'b1;
        #1;
        chk("rstmid_ar_r_low", 64'({arvalid_o, rready_o}), 64'd0);
        chk("rstmid_no_pulse", 64'({mem_ready_o, if_ready_o}), 64'd0);
        chk("rstmid_rdata_clr", mem_rdata_o, 64'd0);
        mem_read_i = 1'b0;
        last_mem_rd = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        r_lat = 0;
        @(negedge clk);
        rd_data_v = 64'h5555_6666_7777_8888;
        sb.push_back('{0, 64'h5555_6666_7777_8888, 0});
        mem_txn(0, 32'h408, '0, '0);
        last_mem_rd = 64'h5555_6666_7777_8888;
        @(negedge clk);

        // three back-to-back reads with the request held
        rd_data_v = 64'h7777_8888_9999_AAAA;
        a0 = n_ar;
        for (int t = 0; t < 3; t++) sb.push_back('{0, 64'h7777_8888_9999_AAAA, 0});
        mem_addr_i = 32'h500; mem_read_i = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_mem("b2b_done");
            chk("b2b_no_ar_in_pulse", 64'(arvalid_o), 64'd0);
            if (t < 2) begin
                @(negedge clk);
                chk("b2b_idle_gap", 64'(arvalid_o), 64'd0);
                @(negedge clk);
                chk("b2b_regrant", 64'(arvalid_o), 64'd1);
            end
        end
        mem_read_i = 1'b0;
        last_mem_rd = 64'h7777_8888_9999_AAAA;
        repeat (3) @(negedge clk);
        chk("b2b_ar_count", 64'(n_ar - a0), 64'd3);
        chk("idle_no_axi", 64'({arvalid_o, awvalid_o, wvalid_o}), 64'd0);

        chk("axi_protocol", 64'(prot_errs), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
